// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle main control unit.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB. It
// drives ALUOp per instruction class for alucontrol plus every datapath strobe.
// It handshakes with variable-latency instruction/data memories, flags halt and
// illegal opcodes, and counts retired instructions.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   opcode          instruction-register opcode, sampled in DECODE only
//   imem_ready      instruction fetch completes this cycle
//   dmem_ready      data access completes this cycle
//   branch_cond     ALU compare result, used in EXEC for branches
//   ALUOp           class code to alucontrol
//   imem_req, ir_write, pc_inc, pc_branch, pc_jump, alu_src,
//   dmem_req, dmem_we, reg_write, mem_to_reg   datapath strobes
//   halted, illegal sticky status flags
//   instr_count     retired-instruction counter (wraps)
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             branch_cond,
  output logic [1:0]       ALUOp,
  output logic             imem_req,
  output logic             ir_write,
  output logic             pc_inc,
  output logic             pc_branch,
  output logic             pc_jump,
  output logic             alu_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q;
  logic       retire;

  logic is_r, is_i, is_br, is_ld, is_st, is_j;
  always_comb begin
    is_r  = (op_q == 6'd0);
    is_i  = (op_q >= 6'd1)  && (op_q <= 6'd7);
    is_br = (op_q >= 6'd8)  && (op_q <= 6'd13);
    is_ld = (op_q == 6'd14);
    is_st = (op_q == 6'd15);
    is_j  = (op_q == 6'd16);
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    ALUOp      = 2'd2;
    imem_req   = 1'b0;
    ir_write   = 1'b0;
    pc_inc     = 1'b0;
    pc_branch  = 1'b0;
    pc_jump    = 1'b0;
    alu_src    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    // Outputs stay at their idle defaults while rst is high, whatever state holds.
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_inc   = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode >= 6'd17) state_d = S_STOP;
          else                 state_d = S_EXEC;
        end
        S_EXEC: begin
          if (is_r) begin
            ALUOp   = 2'd3;
            state_d = S_WB;
          end else if (is_i) begin
            ALUOp   = 2'd1;
            alu_src = 1'b1;
            state_d = S_WB;
          end else if (is_br) begin
            ALUOp     = 2'd0;
            pc_branch = branch_cond;
            retire    = 1'b1;
            state_d   = S_FETCH;
          end else if (is_j) begin
            pc_jump = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (is_ld || is_st) begin
            alu_src = 1'b1;
            state_d = S_MEM;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_MEM: begin
          alu_src  = 1'b1;
          dmem_req = 1'b1;
          dmem_we  = is_st;
          if (dmem_ready) begin
            if (is_st) begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_ld;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_STOP:  state_d = S_STOP;
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        if (opcode == 6'd17) halted  <= 1'b1;
        if (opcode >= 6'd18) illegal <= 1'b1;
      end
      if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        imem_ready, dmem_ready, branch_cond;

  logic [1:0]  ALUOp, ALUOp_s;
  logic        imem_req, ir_write, pc_inc, pc_branch, pc_jump, alu_src;
  logic        dmem_req, dmem_we, reg_write, mem_to_reg, halted, illegal;
  logic [31:0] instr_count;

  logic        imem_req_s, ir_write_s, pc_inc_s, pc_branch_s, pc_jump_s, alu_src_s;
  logic        dmem_req_s, dmem_we_s, reg_write_s, mem_to_reg_s, halted_s, illegal_s;
  logic [2:0]  instr_count_s;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_cond(branch_cond), .ALUOp(ALUOp),
    .imem_req(imem_req), .ir_write(ir_write), .pc_inc(pc_inc),
    .pc_branch(pc_branch), .pc_jump(pc_jump), .alu_src(alu_src),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .halted(halted), .illegal(illegal),
    .instr_count(instr_count)
  );

  // Narrow-counter instance sharing the stimulus, used to reach the wrap point.
  multicycle_ctrl #(.CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_cond(branch_cond), .ALUOp(ALUOp_s),
    .imem_req(imem_req_s), .ir_write(ir_write_s), .pc_inc(pc_inc_s),
    .pc_branch(pc_branch_s), .pc_jump(pc_jump_s), .alu_src(alu_src_s),
    .dmem_req(dmem_req_s), .dmem_we(dmem_we_s), .reg_write(reg_write_s),
    .mem_to_reg(mem_to_reg_s), .halted(halted_s), .illegal(illegal_s),
    .instr_count(instr_count_s)
  );

  // Strobe order: imem_req ir_write pc_inc pc_branch pc_jump alu_src dmem_req dmem_we reg_write mem_to_reg
  localparam logic [9:0] S0    = 10'b0000000000;
  localparam logic [9:0] S_F   = 10'b1000000000;
  localparam logic [9:0] S_FR  = 10'b1110000000;
  localparam logic [9:0] S_BR  = 10'b0001000000;
  localparam logic [9:0] S_J   = 10'b0000100000;
  localparam logic [9:0] S_SRC = 10'b0000010000;
  localparam logic [9:0] S_MR  = 10'b0000011000;
  localparam logic [9:0] S_MW  = 10'b0000011100;
  localparam logic [9:0] S_WB  = 10'b0000000010;
  localparam logic [9:0] S_WBL = 10'b0000000011;

  typedef struct {
    logic        rst;
    logic [5:0]  opc;
    logic        ir, dr, bc;
    logic [1:0]  aluop;
    logic [9:0]  str;
    int unsigned cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [5:0] o, logic i, logic d, logic b,
                              logic [1:0] a, logic [9:0] s, int unsigned c);
    vec_t v;
    v.rst = r; v.opc = o; v.ir = i; v.dr = d; v.bc = b;
    v.aluop = a; v.str = s; v.cnt = c;
    return v;
  endfunction

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Apply inputs, let combinational outputs settle, check both instances, then clock.
  task automatic cyc(string nm, logic r, logic [5:0] o, logic i, logic d, logic b,
                     logic [1:0] a, logic [9:0] s, int unsigned c, logic eh, logic ei);
    logic [9:0]  act, act_s;
    logic [31:0] c32;
    rst = r; opcode = o; imem_ready = i; dmem_ready = d; branch_cond = b;
    #1;
    c32 = c;
    act   = {imem_req, ir_write, pc_inc, pc_branch, pc_jump, alu_src,
             dmem_req, dmem_we, reg_write, mem_to_reg};
    act_s = {imem_req_s, ir_write_s, pc_inc_s, pc_branch_s, pc_jump_s, alu_src_s,
             dmem_req_s, dmem_we_s, reg_write_s, mem_to_reg_s};
    cmp({nm, ".aluop"},   {30'd0, ALUOp}, {30'd0, a});
    cmp({nm, ".strobes"}, {22'd0, act},   {22'd0, s});
    cmp({nm, ".strobes_s"}, {22'd0, act_s}, {22'd0, s});
    cmp({nm, ".count"},   instr_count,    c32);
    cmp({nm, ".count_s"}, {29'd0, instr_count_s}, {29'd0, c32[2:0]});
    cmp({nm, ".flags"},   {30'd0, halted, illegal}, {30'd0, eh, ei});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_cond = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then R-type
    tbl.push_back(mk(1, 0, 1, 1, 1, 2, S0,    0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, S_FR,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S0,    0));
    tbl.push_back(mk(0, 63, 0, 0, 0, 3, S0,   0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_WB,  0));
    // I-type 5 with one fetch wait; opcode input changes after DECODE
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_F,   1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, S_FR,  1));
    tbl.push_back(mk(0, 5, 0, 0, 0, 2, S0,    1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, S_SRC, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_WB,  1));
    // Load 14 with dmem_ready delayed 3 cycles; early dmem_ready ignored
    tbl.push_back(mk(0, 0, 1, 1, 0, 2, S_FR,  2));
    tbl.push_back(mk(0, 14, 0, 1, 0, 2, S0,   2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_SRC, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_MR,  2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_MR,  2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_MR,  2));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2, S_MR,  2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_WBL, 2));
    // Branch 9 taken
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, S_FR,  3));
    tbl.push_back(mk(0, 9, 0, 0, 0, 2, S0,    3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, S_BR,  3));
    // Branch 9 not taken; branch_cond high outside EXEC does nothing
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, S_FR,  4));
    tbl.push_back(mk(0, 9, 0, 0, 1, 2, S0,    4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, S0,    4));
    // Store 15, zero wait
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, S_FR,  5));
    tbl.push_back(mk(0, 15, 0, 0, 0, 2, S0,   5));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_SRC, 5));
    tbl.push_back(mk(0, 0, 0, 1, 0, 2, S_MW,  5));
    // Jump 16
    tbl.push_back(mk(0, 0, 1, 0, 0, 2, S_FR,  6));
    tbl.push_back(mk(0, 16, 0, 0, 0, 2, S0,   6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_J,   6));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, S_F,   7));

    foreach (tbl[i])
      cyc($sformatf("row%0d", i), tbl[i].rst, tbl[i].opc, tbl[i].ir, tbl[i].dr,
          tbl[i].bc, tbl[i].aluop, tbl[i].str, tbl[i].cnt, 1'b0, 1'b0);

    // Reset inside a MEM wait while the narrow counter sits at its maximum
    cyc("rm_fetch", 0, 15, 1, 0, 0, 2, S_FR, 7, 0, 0);
    cyc("rm_dec",   0, 15, 0, 0, 0, 2, S0,   7, 0, 0);
    cyc("rm_exec",  0, 0,  0, 0, 0, 2, S_SRC, 7, 0, 0);
    cyc("rm_wait",  0, 0,  0, 0, 0, 2, S_MW, 7, 0, 0);
    cyc("rm_rst1",  1, 0,  1, 1, 1, 2, S0,   7, 0, 0);
    cyc("rm_rst2",  1, 0,  1, 1, 1, 2, S0,   0, 0, 0);
    cyc("rm_rel",   0, 0,  0, 0, 0, 2, S_F,  0, 0, 0);

    // Seven jumps bring the narrow counter to 7; an R-type then wraps it
    for (int k = 0; k < 7; k++) begin
      cyc($sformatf("j%0d_f", k), 0, 0,  1, 0, 0, 2, S_FR, k, 0, 0);
      cyc($sformatf("j%0d_d", k), 0, 16, 0, 0, 0, 2, S0,   k, 0, 0);
      cyc($sformatf("j%0d_e", k), 0, 0,  0, 0, 0, 2, S_J,  k, 0, 0);
    end
    cyc("wr_f", 0, 0, 1, 0, 0, 2, S_FR, 7, 0, 0);
    cyc("wr_d", 0, 0, 0, 0, 0, 2, S0,   7, 0, 0);
    cyc("wr_e", 0, 0, 0, 0, 0, 3, S0,   7, 0, 0);
    cyc("wr_w", 0, 0, 0, 0, 0, 2, S_WB, 7, 0, 0);
    cyc("wr_n", 0, 0, 0, 0, 0, 2, S_F,  8, 0, 0);

    // Halt: terminal, strobes idle, count frozen
    cyc("h_f", 0, 17, 1, 0, 0, 2, S_FR, 8, 0, 0);
    cyc("h_d", 0, 17, 0, 0, 0, 2, S0,   8, 0, 0);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("h_stop%0d", k), 0, 0, 1, 1, 1, 2, S0, 8, 1, 0);

    // Reset out of STOP, then an illegal opcode
    cyc("il_rst", 1, 0,  1, 1, 1, 2, S0,   8, 1, 0);
    cyc("il_f",   0, 40, 1, 0, 0, 2, S_FR, 0, 0, 0);
    cyc("il_d",   0, 40, 0, 0, 0, 2, S0,   0, 0, 0);
    for (int k = 0; k < 3; k++)
      cyc($sformatf("il_stop%0d", k), 0, 0, 1, 1, 1, 2, S0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
